// File: rtl/axi_lite_gpio_irq.sv
// AXI4-Lite GPIO: synchronised inputs, SET/CLR, per-pin edge interrupts (W1C) and one level irq.
// B follows one cycle after AW and W are both held; R one cycle after AR; a pending response stalls its channel.
module axi_lite_gpio_irq #(
  parameter int NUM_CHANNELS = 2,
  parameter int GPIO_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [ADDR_WIDTH-1:0]              s_axi_awaddr,
  input  logic [2:0]                         s_axi_awprot,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [31:0]                        s_axi_wdata,
  input  logic [3:0]                         s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic [2:0]                         s_axi_arprot,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [31:0]                        s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  input  logic [NUM_CHANNELS*GPIO_WIDTH-1:0] gpio_io_i,
  output logic [NUM_CHANNELS*GPIO_WIDTH-1:0] gpio_io_o,
  output logic [NUM_CHANNELS*GPIO_WIDTH-1:0] gpio_io_t,
  output logic                               irq
);

  localparam int NW = NUM_CHANNELS * GPIO_WIDTH;
  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_held_q, w_held_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [31:0]           rdata_q;

  logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NUM_CHANNELS-1:0][GPIO_WIDTH-1:0] status_q, status_d, sync_val, prev_q, hw_set;
  logic                  gie_q, gie_d, irq_q;
  logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
  logic [2:0]            prime_q;

  logic aw_hs, w_hs, ar_hs, do_write, wr_ok, rd_ok;
  logic [31:0] wr_mask, wr_bits, rd_val;
  logic [GPIO_WIDTH-1:0] gw_mask, gw_bits;
  logic unused_ok;

  function automatic logic addr_is_gie(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(32);
  endfunction

  function automatic logic addr_is_chan(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:7] == '0) && (int'(a[6:5]) < NUM_CHANNELS) && (a[4:2] != 3'd7);
  endfunction

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, awaddr_q[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ~areset & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = ~areset & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = ~areset & ~rvalid_q;
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign do_write = aw_held_q & w_held_q;
  assign wr_ok    = addr_is_chan(awaddr_q) | addr_is_gie(awaddr_q);
  assign rd_ok    = addr_is_chan(s_axi_araddr) | addr_is_gie(s_axi_araddr);

  assign wr_mask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign wr_bits  = wdata_q & wr_mask;
  assign gw_mask  = wr_mask[GPIO_WIDTH-1:0];
  assign gw_bits  = wr_bits[GPIO_WIDTH-1:0];
  assign sync_val = sync_q[SYNC_STAGES-1];

  // Edges are ignored until the synchroniser and prev flop hold real pad samples.
  always_comb begin
    hw_set = '0;
    if (prime_q == PRIME_DONE) begin
      hw_set = ((sync_val & ~prev_q & rise_en_q) | (~sync_val & prev_q & fall_en_q)) & ~dir_q;
    end
  end

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    gie_d     = gie_q;
    if (do_write && addr_is_gie(awaddr_q) && wstrb_q[0]) begin
      gie_d = wdata_q[0];
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (do_write && addr_is_chan(awaddr_q) && int'(awaddr_q[6:5]) == c) begin
        case (awaddr_q[4:2])
          3'd0:    out_d[c]     = (out_q[c] & ~gw_mask) | gw_bits;
          3'd1:    dir_d[c]     = (dir_q[c] & ~gw_mask) | gw_bits;
          3'd2:    out_d[c]     = out_q[c] | gw_bits;
          3'd3:    out_d[c]     = out_q[c] & ~gw_bits;
          3'd4:    rise_en_d[c] = (rise_en_q[c] & ~gw_mask) | gw_bits;
          3'd5:    fall_en_d[c] = (fall_en_q[c] & ~gw_mask) | gw_bits;
          3'd6:    status_d[c]  = status_q[c] & ~gw_bits;
          default: ;
        endcase
      end
    end
    // A new event in the same cycle as its W1C must survive.
    status_d = status_d | hw_set;
  end

  always_comb begin
    rd_val = '0;
    if (addr_is_gie(s_axi_araddr)) begin
      rd_val[0] = gie_q;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (addr_is_chan(s_axi_araddr) && int'(s_axi_araddr[6:5]) == c) begin
        case (s_axi_araddr[4:2])
          3'd0:    rd_val[GPIO_WIDTH-1:0] = (dir_q[c] & out_q[c]) | (~dir_q[c] & sync_val[c]);
          3'd1:    rd_val[GPIO_WIDTH-1:0] = dir_q[c];
          3'd4:    rd_val[GPIO_WIDTH-1:0] = rise_en_q[c];
          3'd5:    rd_val[GPIO_WIDTH-1:0] = fall_en_q[c];
          3'd6:    rd_val[GPIO_WIDTH-1:0] = status_q[c];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      gie_q     <= 1'b0;
      irq_q     <= 1'b0;
      sync_q    <= '0;
      prev_q    <= '0;
      prime_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
      end
      if (do_write) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_ok ? 2'b00 : 2'b10;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      gie_q     <= gie_d;
      irq_q     <= gie_q & (|status_q);
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_io_i};
      prev_q    <= sync_val;
      if (prime_q != PRIME_DONE) begin
        prime_q <= prime_q + 3'd1;
      end
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign gpio_io_o    = out_q;
  assign gpio_io_t    = ~dir_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_axi_lite_gpio_irq.sv
// Directed bench for axi_lite_gpio_irq (2 channels x 32 pins, 2 sync stages).
module tb_axi_lite_gpio_irq;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic [63:0] gpio_io_i = '0, gpio_io_o, gpio_io_t;
  int checks = 0, errors = 0;

  axi_lite_gpio_irq #(.NUM_CHANNELS(2), .GPIO_WIDTH(32), .SYNC_STAGES(2), .ADDR_WIDTH(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .gpio_io_i(gpio_io_i), .gpio_io_o(gpio_io_o), .gpio_io_t(gpio_io_t), .irq(irq)
  );

  always #5 aclk = ~aclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(1);
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(1); n++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    resp = bresp;
    bready = 1'b1; tick(1); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done;
    int n;
    done = 0; n = 0;
    araddr = a; arvalid = 1'b1;
    while (!done && n < 20) begin done = arready; tick(1); n++; end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(1); n++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1; tick(1); rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(3);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b required 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid got %b required 00", {bvalid, rvalid});
    end
    checks++;
    if (gpio_io_o !== 64'h0) begin errors++; $display("FAIL reset_out got %h required 0", gpio_io_o); end
    checks++;
    if (gpio_io_t !== {64{1'b1}}) begin errors++; $display("FAIL reset_tri got %h required all ones", gpio_io_t); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b required 0", irq); end
    areset = 1'b0;
    tick(1);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_set_clr();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'h04, 32'h0000_00FF, 4'hF, r);
    axi_write(8'h08, 32'h0000_000F, 4'hF, r);
    axi_write(8'h0C, 32'h0000_0003, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL setclr_bresp got %b required 00", r); end
    checks++;
    if (gpio_io_o !== 64'h0C) begin errors++; $display("FAIL setclr_out got %h required 0c", gpio_io_o); end
    checks++;
    if (gpio_io_t !== 64'hFFFF_FFFF_FFFF_FF00) begin
      errors++; $display("FAIL setclr_tri got %h required ffffffffffffff00", gpio_io_t);
    end
    axi_read(8'h08, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h0}) begin errors++; $display("FAIL set_reads0 got %b/%h required 00/0", r, d); end
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'h0C) begin errors++; $display("FAIL data_read got %h required 0c", d); end
    axi_write(8'h00, 32'hAABB_CCDD, 4'b0001, r);
    checks++;
    if (gpio_io_o !== 64'hDD) begin errors++; $display("FAIL data_strb got %h required dd", gpio_io_o); end
    axi_write(8'h08, 32'hFFFF_FFFF, 4'b0000, r);
    axi_write(8'h0C, 32'h0000_00F0, 4'b0001, r);
    checks++;
    if (gpio_io_o !== 64'h0D) begin errors++; $display("FAIL setclr_strb got %h required 0d", gpio_io_o); end
    gpio_io_i = 64'h0000_0000_FFFF_FFFF;
    tick(3);
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'hFFFF_FF0D) begin errors++; $display("FAIL data_mixed got %h required ffffff0d", d); end
    gpio_io_i = '0;
    tick(3);
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    int nb;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick(1);
    wvalid = 1'b0;
    checks++;
    if ({wready, bvalid} !== 2'b00) begin errors++; $display("FAIL w_held got %b required 00", {wready, bvalid}); end
    tick(1);
    awaddr = 8'h24; awvalid = 1'b1;
    tick(1);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL early_bvalid got %b required 0", bvalid); end
    tick(1);
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL w_first_b got %b required 100", {bvalid, bresp}); end
    checks++;
    if (gpio_io_t[63:32] !== 32'hEDCB_A987) begin
      errors++; $display("FAIL w_first_dir got %h required edcba987", gpio_io_t[63:32]);
    end
    bready = 1'b1; tick(1); bready = 1'b0;
    nb = 0;
    repeat (4) begin if (bvalid) nb++; tick(1); end
    axi_write(8'h24, 32'h0, 4'hF, r);
    repeat (4) begin if (bvalid) nb++; tick(1); end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL extra_bvalid got %0d required 0", nb); end
    checks++;
    if (gpio_io_t[63:32] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL same_cycle_dir got %h required ffffffff", gpio_io_t[63:32]);
    end
  endtask

  task automatic test_irq();
    logic [1:0] r; logic [31:0] d;
    int n;
    axi_write(8'h04, 32'h0, 4'hF, r);
    axi_write(8'h10, 32'h1, 4'hF, r);
    axi_write(8'h80, 32'h1, 4'hF, r);
    gpio_io_i[0] = 1'b1;
    n = 0;
    while (!irq && n < 5) begin tick(1); n++; end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b after %0d cycles required 1", irq, n); end
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_rise got %h required 1", d); end
    axi_write(8'h18, 32'h1, 4'hF, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b required 0", irq); end
    gpio_io_i[0] = 1'b0;
    tick(5);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL fall_not_enabled got %h required 0", d); end
  endtask

  task automatic test_prime_and_fall();
    logic [1:0] r; logic [31:0] d;
    gpio_io_i = 64'h3;
    areset = 1'b1;
    tick(4);
    areset = 1'b0;
    axi_write(8'h10, 32'h3, 4'hF, r);
    tick(6);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL prime_status got %h required 0", d); end
    axi_write(8'h10, 32'h0, 4'hF, r);
    axi_write(8'h14, 32'h2, 4'hF, r);
    gpio_io_i[1] = 1'b0;
    tick(5);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL fall_status got %h required 2", d); end
    gpio_io_i[1] = 1'b1;
    tick(5);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL rise_disabled got %h required 2", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_gie_off got %b required 0", irq); end
    axi_write(8'h18, 32'h2, 4'h0, r);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL w1c_strb0 got %h required 2", d); end
    axi_write(8'h80, 32'h1, 4'hF, r);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_gie_on got %b required 1", irq); end
    axi_write(8'h18, 32'h2, 4'hF, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
  endtask

  task automatic test_slverr();
    logic [1:0] r; logic [31:0] d;
    axi_read(8'h40, d, r);
    checks++;
    if ({r, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_0x40 got %b/%h required 10/0", r, d); end
    axi_read(8'h84, d, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL rd_0x84 got %b required 10", r); end
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL wr_0x1c got %b required 10", r); end
    checks++;
    if ({gpio_io_o, gpio_io_t} !== {64'h0, {64{1'b1}}}) begin
      errors++; $display("FAIL wr_0x1c_effect got %h/%h required 0/all ones", gpio_io_o, gpio_io_t);
    end
    axi_read(8'h80, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h1}) begin errors++; $display("FAIL rd_gie got %b/%h required 00/1", r, d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    int nb;
    axi_write(8'h08, 32'hA5, 4'hF, r);
    axi_write(8'h04, 32'hFF, 4'hF, r);
    awaddr = 8'h08; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick(1);
    checks++;
    if ({bvalid, rvalid, gpio_io_o[7:0]} !== {2'b11, 8'hFF}) begin
      errors++; $display("FAIL inflight got %b/%h required 11/ff", {bvalid, rvalid}, gpio_io_o[7:0]);
    end
    areset = 1'b1;
    tick(1);
    checks++;
    if ({bvalid, rvalid, awready, wready, arready, irq} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_hs got %b required 000000", {bvalid, rvalid, awready, wready, arready, irq});
    end
    checks++;
    if ({gpio_io_o, gpio_io_t} !== {64'h0, {64{1'b1}}}) begin
      errors++; $display("FAIL mid_reset_pads got %h/%h required 0/all ones", gpio_io_o, gpio_io_t);
    end
    areset = 1'b0;
    awaddr = 8'h04; awvalid = 1'b1;
    tick(1);
    awvalid = 1'b0; areset = 1'b1;
    tick(1);
    areset = 1'b0;
    wdata = 32'hFF; wvalid = 1'b1;
    tick(1);
    wvalid = 1'b0;
    nb = 0;
    repeat (4) begin if (bvalid) nb++; tick(1); end
    checks++;
    if (nb !== 0 || gpio_io_t !== {64{1'b1}}) begin
      errors++; $display("FAIL held_aw_dropped got bvalid_cycles=%0d tri=%h required 0/all ones", nb, gpio_io_t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_clr();
    test_back_to_back();
    test_irq();
    test_prime_and_fall();
    test_slverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
